// File: rtl/cell_pos_reader.sv
// cell_pos_reader: read-side initiator for one position cell memory.
// Word 0 of the cell holds the particle count and words 1..N hold the
// {posz, posy, posx} records. The block fetches the count, then streams every
// record out on a valid/ready interface. A small credit-controlled FIFO takes
// up the RAM's fixed 2-cycle read latency so the consumer can apply
// backpressure freely.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// CNT_REQ  | reading address 0 (particle count)
// CNT_WAIT | two-cycle read latency; count captured and clamped in 2nd cycle
// STREAM   | issuing reads for addresses 1..count whenever a FIFO credit exists
// DRAIN    | waiting for in-flight reads to land and the FIFO to empty
// DONE     | one-cycle done pulse, then back to IDLE
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_REQ,
        S_CNT_WAIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // read issue and count capture
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  stream_issue;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] count_clamped;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  wait_cnt;

    // return path: two stages matching the RAM latency
    logic                  p1_valid, p2_valid;
    logic [ADDR_WIDTH-1:0] p1_index, p2_index;
    logic                  p1_last,  p2_last;

    // output FIFO
    logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_index [FIFO_DEPTH];
    logic                  fifo_last  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  push, pop;

    // credit accounting
    logic [1:0]            in_flight;
    logic [OCC_W:0]        pending;
    logic                  room;

    assign count_clamped = (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT
                                                               : mem_q[ADDR_WIDTH-1:0];

    assign push      = p2_valid;
    assign pop       = out_valid & out_ready;
    assign in_flight = {1'b0, p1_valid} + {1'b0, p2_valid};
    // A read is only issued when a FIFO slot is guaranteed for its data, so
    // the FIFO can never overflow however long the consumer stalls.
    assign pending   = (OCC_W+1)'(occ) + (OCC_W+1)'(in_flight);
    assign room      = pending < (OCC_W+1)'(FIFO_DEPTH);

    assign stream_issue = issue & (state == S_STREAM);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state and read-issue decode
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_addr = next_addr;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CNT_REQ;
            end
            S_CNT_REQ: begin
                issue      = 1'b1;
                issue_addr = '0;
                state_nxt  = S_CNT_WAIT;
            end
            S_CNT_WAIT: begin
                if (wait_cnt == 1'b0) begin
                    capture   = 1'b1;
                    state_nxt = (count_clamped == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (room) begin
                    issue = 1'b1;
                    if (next_addr == particle_count) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // leave as soon as the final beat is being handed over
                if (!p1_valid && !p2_valid &&
                    (occ == '0 || (occ == OCC_W'(1) && pop)))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // count-read latency down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       wait_cnt <= 1'b0;
        else if (state == S_CNT_REQ)                   wait_cnt <= 1'b1;
        else if (state == S_CNT_WAIT && wait_cnt != 1'b0) wait_cnt <= wait_cnt - 1'b1;
    end

    // particle count capture and read address sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            particle_count <= '0;
            next_addr      <= '0;
            last_addr      <= '0;
        end else begin
            if (capture) begin
                particle_count <= count_clamped;
                next_addr      <= ADDR_WIDTH'(1);
            end else if (stream_issue) begin
                next_addr <= next_addr + 1'b1;
            end
            if (issue) last_addr <= issue_addr;
        end
    end

    // return-path tag pipeline (count read is not tagged, so never pushed)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_index <= '0;
            p1_last  <= 1'b0;
            p2_valid <= 1'b0;
            p2_index <= '0;
            p2_last  <= 1'b0;
        end else begin
            p1_valid <= stream_issue;
            p1_index <= next_addr - 1'b1;
            p1_last  <= (next_addr == particle_count);
            p2_valid <= p1_valid;
            p2_index <= p1_index;
            p2_last  <= p1_last;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i]  <= '0;
                fifo_index[i] <= '0;
                fifo_last[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr]  <= mem_q;
                fifo_index[wr_ptr] <= p2_index;
                fifo_last[wr_ptr]  <= p2_last;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign out_valid   = (occ != '0);
    assign out_data    = fifo_data[rd_ptr];
    assign out_index   = fifo_index[rd_ptr];
    assign out_last    = fifo_last[rd_ptr];

    assign mem_rden    = issue;
    assign mem_address = issue ? issue_addr : last_addr;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;

    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);

endmodule

// File: doc/cell_pos_reader.md
Name: cell_pos_reader

Overview:
Read-side initiator for one position cell memory: single-port RAM, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}.
- On start, fetches the count, then streams every particle record out on a valid/ready interface with a 0-based particle index and a last flag.
- Absorbs the RAM's fixed read latency against downstream backpressure with a credit-controlled output FIFO.
- Feeds force-evaluation and motion-update consumers that cannot accept fixed-latency data.

Parameters:
DATA_WIDTH, 96, width of one position record {posz, posy, posx}, 32 bits each
ADDR_WIDTH, 8, cell memory address width
PARTICLE_NUM, 220, memory depth in words; maximum legal count is PARTICLE_NUM-1
FIFO_DEPTH, 4, output buffer entries; minimum 4, power of two

Ports:
clk  in  1  single clock for the whole block
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to stream the cell; ignored unless idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last particle handshake, or after the count is captured when count = 0
particle_count  out  ADDR_WIDTH  count captured from address 0, after clamping
mem_address  out  ADDR_WIDTH  cell memory address
mem_rden  out  1  cell memory read enable
mem_wren  out  1  tied 0
mem_data  out  DATA_WIDTH  tied 0
mem_q  in  DATA_WIDTH  cell memory read data, valid 2 cycles after the rden cycle
out_valid  out  1  out_data, out_index and out_last are valid
out_ready  in  1  consumer accepts the current beat
out_data  out  DATA_WIDTH  particle position record
out_index  out  ADDR_WIDTH  0-based particle index (memory address - 1)
out_last  out  1  marks the final particle of the cell

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; FIFO empty; in-flight read pipeline cleared.
  - All outputs 0: busy, done, particle_count, mem_address, mem_rden, out_valid, out_data, out_index, out_last.
  - Reads issued before reset are discarded and never enter the FIFO.
- States:
  - IDLE -> CNT_REQ on start.
  - CNT_REQ: one cycle; mem_address=0, mem_rden=1.
  - CNT_WAIT: two cycles; capture mem_q[ADDR_WIDTH-1:0] in the second cycle.
  - Clamp: if the captured count > PARTICLE_NUM-1, particle_count = PARTICLE_NUM-1.
  - CNT_WAIT -> DONE if count = 0, else -> STREAM.
  - STREAM: issue reads for addresses 1..count in ascending order. -> DRAIN after address count is issued.
  - DRAIN: wait until all in-flight reads have landed and the FIFO has emptied through handshakes. -> DONE.
  - DONE: done=1 for one cycle, busy drops in the same cycle, -> IDLE.
- Read issue rule:
  - A read may issue in a cycle only if in_flight + fifo_occupancy < FIFO_DEPTH. in_flight counts reads issued but not yet written to the FIFO (0..2).
  - The FIFO therefore never overflows, and no read is ever dropped or repeated.
  - When no read issues, mem_rden=0; mem_address holds its last value.
- Return path: a 2-deep valid/index shift register tracks mem_rden. Data is written into the FIFO in the cycle mem_q is valid, tagged with index = addr-1 and last = (addr == count).
- Output interface:
  - out_valid = FIFO non-empty; head fields are driven directly from the FIFO.
  - A handshake (out_valid & out_ready) pops the head.
  - out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
  - Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.
- Timing, start accepted in cycle 0:
  - Cycle 1: address 0 read.
  - Cycle 3: count captured.
  - Cycle 4: address 1 read.
  - Cycle 7: first out_valid.
  - With out_ready held high, throughput is 1 particle per cycle; the last beat is in cycle 6+count and done pulses in cycle 7+count.
- Start during busy is ignored with no side effects. Start in the DONE cycle is also ignored.
- mem_wren and mem_data are held 0 at all times; this block never writes the cell.

Test Plan:
- Count 3, records A1..A3 at addresses 1..3, out_ready=1, start at cycle 0 -> rden at address 0 in cycle 1 and addresses 1..3 in cycles 4..6; beats (A1,0), (A2,1), (A3,2,last) in cycles 7..9; done in cycle 10; particle_count=3.
- Count 0 -> no reads beyond address 0; out_valid never asserts; done in cycle 4.
- Count 5, out_ready low for cycles 7..14 -> at most 4 reads outstanding or buffered, no rden while full; all 5 beats delivered in order with indices 0..4; data held stable while stalled.
- Address 0 holds 250 -> particle_count=219; addresses 1..219 are read and 219 beats are produced.
- Count 10, rst pulsed after the 4th beat -> all outputs 0 immediately; a new start produces a clean stream from index 0 with no stale beats.
- start pulsed again in cycle 5 of a count-3 run -> ignored; exactly 3 beats and one done pulse.
